alu: RTL and testbench



---
 rtl/alu.sv | 200 ++++++++++++++++++++
 tb/tb_alu.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// S-Machine stack-execution unit: one instruction per start handshake, executed
// against a circular operand stack, with a done/PC strobe on completion.
module alu #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] inst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in_memory,
    input  logic             read_write_memory,
    output logic [WIDTH-1:0] data_out_memory,
    output logic             done,
    output logic             PC
);

    localparam int SP_W = $clog2(DEPTH);

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_PUSHI = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_STORE = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_SUB   = 4'h5;
    localparam logic [3:0] OP_AND   = 4'h6;
    localparam logic [3:0] OP_OR    = 4'h7;
    localparam logic [3:0] OP_XOR   = 4'h8;
    localparam logic [3:0] OP_SHR   = 4'h9;
    localparam logic [3:0] OP_SHL   = 4'hA;
    localparam logic [3:0] OP_DUP   = 4'hB;
    localparam logic [3:0] OP_DROP  = 4'hC;
    localparam logic [3:0] OP_SWAP  = 4'hD;
    localparam logic [3:0] OP_NOT   = 4'hE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] inst_r;
    logic [SP_W-1:0]  sp_r;
    logic [SP_W-1:0]  sp_next_s;
    logic [SP_W-1:0]  sp_p1_s;
    logic [SP_W-1:0]  sp_m1_s;
    logic [WIDTH-1:0] stk_r      [DEPTH];
    logic [WIDTH-1:0] stk_next_s [DEPTH];
    logic [WIDTH-1:0] t_s;
    logic [WIDTH-1:0] n_s;
    logic [WIDTH-1:0] imm_s;
    logic [3:0]       op_s;
    logic             exec_fire_s;
    logic             store_s;
    logic [WIDTH-1:0] dout_r;
    logic             done_r;
    logic             pc_r;

    assign op_s     = inst_r[WIDTH-1 -: 4];
    assign imm_s    = {{(WIDTH-12){inst_r[11]}}, inst_r[11:0]};
    assign sp_p1_s  = sp_r + SP_W'(1);
    assign sp_m1_s  = sp_r - SP_W'(1);
    assign t_s      = stk_r[sp_r];
    assign n_s      = stk_r[sp_m1_s];

    // A LOAD only completes once memory reports valid read data.
    assign exec_fire_s = (state_r == EXEC) && ((op_s != OP_LOAD) || read_write_memory);

    assign data_out_memory = dout_r;
    assign done            = done_r;
    assign PC              = pc_r;

    // Next-state logic for the IDLE -> EXEC -> FIN handshake.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = EXEC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXEC: begin
                if (exec_fire_s) begin
                    state_next_s = FIN;
                end else begin
                    state_next_s = EXEC;
                end
            end
            FIN:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Stack and pointer update for the instruction firing this cycle.
    always_comb begin
        sp_next_s = sp_r;
        store_s   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            stk_next_s[i] = stk_r[i];
        end
        if (exec_fire_s) begin
            case (op_s)
                OP_PUSHI: begin
                    sp_next_s           = sp_p1_s;
                    stk_next_s[sp_p1_s] = imm_s;
                end
                OP_LOAD: begin
                    sp_next_s           = sp_p1_s;
                    stk_next_s[sp_p1_s] = data_in_memory;
                end
                OP_STORE: begin
                    store_s   = 1'b1;
                    sp_next_s = sp_m1_s;
                end
                OP_ADD: begin
                    sp_next_s           = sp_m1_s;
                    stk_next_s[sp_m1_s] = n_s + t_s;
                end
                OP_SUB: begin
                    sp_next_s           = sp_m1_s;
                    stk_next_s[sp_m1_s] = n_s - t_s;
                end
                OP_AND: begin
                    sp_next_s           = sp_m1_s;
                    stk_next_s[sp_m1_s] = n_s & t_s;
                end
                OP_OR: begin
                    sp_next_s           = sp_m1_s;
                    stk_next_s[sp_m1_s] = n_s | t_s;
                end
                OP_XOR: begin
                    sp_next_s           = sp_m1_s;
                    stk_next_s[sp_m1_s] = n_s ^ t_s;
                end
                OP_SHR:  stk_next_s[sp_r] = t_s >> 1;
                OP_SHL:  stk_next_s[sp_r] = t_s << 1;
                OP_DUP: begin
                    sp_next_s           = sp_p1_s;
                    stk_next_s[sp_p1_s] = t_s;
                end
                OP_DROP: sp_next_s = sp_m1_s;
                OP_SWAP: begin
                    stk_next_s[sp_r]    = n_s;
                    stk_next_s[sp_m1_s] = t_s;
                end
                OP_NOT:  stk_next_s[sp_r] = ~t_s;
                OP_NOP:  sp_next_s = sp_r;
                // Reserved opcode 4'hF behaves as NOP but still completes.
                default: sp_next_s = sp_r;
            endcase
        end else begin
            sp_next_s = sp_r;
        end
    end

    // FSM state, latched instruction and completion strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            inst_r  <= '0;
            done_r  <= 1'b0;
            pc_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if ((state_r == IDLE) && start) begin
                inst_r <= inst;
            end else begin
                inst_r <= inst_r;
            end
            done_r <= (state_r == FIN);
            pc_r   <= (state_r == FIN);
        end
    end

    // Operand stack, stack pointer and memory write-data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_r   <= '0;
            dout_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stk_r[i] <= WIDTH'(1);
            end
        end else begin
            sp_r <= sp_next_s;
            if (store_s) begin
                dout_r <= t_s;
            end else begin
                dout_r <= dout_r;
            end
            for (int i = 0; i < DEPTH; i++) begin
                stk_r[i] <= stk_next_s[i];
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the alu stack unit; the top of stack is
// observed through STORE on data_out_memory.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [15:0] inst;
    logic        start;
    logic [15:0] data_in_memory;
    logic        read_write_memory;
    logic [15:0] data_out_memory;
    logic        done;
    logic        PC;

    int n_checks;
    int n_fail;
    int cnt;

    alu #(.DEPTH(8), .WIDTH(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .inst              (inst),
        .start             (start),
        .data_in_memory    (data_in_memory),
        .read_write_memory (read_write_memory),
        .data_out_memory   (data_out_memory),
        .done              (done),
        .PC                (PC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One-cycle start pulse, then expect exactly one done and one PC pulse.
    task automatic run(input logic [15:0] op, input string tag);
        int nd;
        int np;
        nd = 0;
        np = 0;
        @(negedge clk);
        inst  = op;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        inst  = 16'hFFFF;
        repeat (5) begin
            if (done === 1'b1) nd++;
            if (PC === 1'b1) np++;
            @(negedge clk);
        end
        check({tag, "_done_cnt"}, 16'(nd), 16'd1);
        check({tag, "_pc_cnt"}, 16'(np), 16'd1);
    endtask

    task automatic store_expect(input logic [15:0] exp, input string tag);
        run(16'h3000, tag);
        check(tag, data_out_memory, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        rst_n             = 1'b0;
        inst              = 16'h0000;
        start             = 1'b0;
        data_in_memory    = 16'h0000;
        read_write_memory = 1'b0;
        #1;
        check("reset_done", {15'd0, done}, 16'd0);
        check("reset_pc", {15'd0, PC}, 16'd0);
        check("reset_dout", data_out_memory, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ADD with exact done timing: high only after the third edge.
        @(negedge clk);
        inst  = 16'h4000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("add_t1_done", {15'd0, done}, 16'd0);
        @(negedge clk);
        check("add_t2_done", {15'd0, done}, 16'd0);
        @(negedge clk);
        check("add_t3_done", {15'd0, done}, 16'd1);
        check("add_t3_pc", {15'd0, PC}, 16'd1);
        @(negedge clk);
        check("add_t4_done", {15'd0, done}, 16'd0);
        check("add_t4_pc", {15'd0, PC}, 16'd0);
        store_expect(16'h0002, "add_result");

        // SUB, then SHR on the next 1 below it.
        do_reset();
        run(16'h5000, "sub");
        store_expect(16'h0000, "sub_result");
        run(16'h1123, "pushi_123");
        store_expect(16'h0123, "pushi_123_result");
        run(16'h9000, "shr");
        store_expect(16'h0000, "shr_result");

        // Sign extension and modular ADD.
        do_reset();
        run(16'h1FFF, "pushi_neg1");
        run(16'hB000, "dup_neg1");
        store_expect(16'hFFFF, "pushi_sext");
        run(16'h1002, "pushi_2");
        run(16'h4000, "add_wrap");
        store_expect(16'h0001, "add_wrap_result");

        // Logic ops on 0xC and 0xA.
        run(16'h100C, "pc_and");
        run(16'h100A, "pa_and");
        run(16'h6000, "and");
        store_expect(16'h0008, "and_result");
        run(16'h100C, "pc_or");
        run(16'h100A, "pa_or");
        run(16'h7000, "or");
        store_expect(16'h000E, "or_result");
        run(16'h100C, "pc_xor");
        run(16'h100A, "pa_xor");
        run(16'h8000, "xor");
        store_expect(16'h0006, "xor_result");

        // SWAP then SUB gives 3 - 5.
        run(16'h1005, "p5");
        run(16'h1003, "p3");
        run(16'hD000, "swap");
        run(16'h5000, "sub_swapped");
        store_expect(16'hFFFE, "swap_sub_result");

        run(16'h1800, "pushi_800");
        run(16'hA000, "shl");
        store_expect(16'hF000, "shl_result");

        // DROP, NOP and reserved leave 7 on top; NOT inverts it.
        run(16'h1007, "p7");
        run(16'h1009, "p9");
        run(16'hC000, "drop");
        run(16'h0000, "nop");
        run(16'hF000, "reserved");
        run(16'hE000, "not");
        store_expect(16'hFFF8, "not_result");

        // LOAD with four wait cycles.
        @(negedge clk);
        inst              = 16'h2000;
        start             = 1'b1;
        read_write_memory = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cnt   = 0;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        check("load_wait_no_done", 16'(cnt), 16'd0);
        data_in_memory    = 16'hBEEF;
        read_write_memory = 1'b1;
        @(negedge clk);
        read_write_memory = 1'b0;
        data_in_memory    = 16'h0000;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        check("load_done_cnt", 16'(cnt), 16'd1);
        store_expect(16'hBEEF, "load_result");

        // Nine DUPs wrap the pointer without disturbing completion.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            run(16'hB000, "dup_wrap");
        end
        store_expect(16'h0001, "dup_wrap_result");

        // Reset in the middle of a LOAD wait.
        run(16'h1055, "p55");
        store_expect(16'h0055, "pre_reset_store");
        @(negedge clk);
        inst              = 16'h2000;
        start             = 1'b1;
        read_write_memory = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midload_rst_done", {15'd0, done}, 16'd0);
        check("midload_rst_pc", {15'd0, PC}, 16'd0);
        check("midload_rst_dout", data_out_memory, 16'h0000);
        @(negedge clk);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        check("midload_no_done", 16'(cnt), 16'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            store_expect(16'h0001, "post_reset_entry");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
